// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0 prefixes into make/break events,
// tracks the held key, suppresses typematic repeats and queues events in a show-ahead FIFO.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic             out_break,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t           state_reg, state_next;
  logic             key_down_reg, key_down_next;
  logic             held_ext_reg, held_ext_next;
  logic [7:0]       held_code_reg, held_code_next;
  logic [CNT_W-1:0] press_count_reg, press_count_next;
  logic             ev_valid;
  logic [9:0]       ev_entry;
  logic             is_ext, is_brk, same_key;

  always_comb begin
    state_next       = state_reg;
    key_down_next    = key_down_reg;
    held_ext_next    = held_ext_reg;
    held_code_next   = held_code_reg;
    press_count_next = press_count_reg;
    ev_valid         = 1'b0;
    ev_entry         = '0;
    is_ext   = (state_reg == S_E0) || (state_reg == S_E0F0);
    is_brk   = (state_reg == S_F0) || (state_reg == S_E0F0);
    same_key = key_down_reg && (held_ext_reg == is_ext) && (held_code_reg == in_data);
    if (in_valid) begin
      case (in_data)
        8'hE0:        state_next = is_brk ? S_E0F0 : S_E0;
        8'hF0:        state_next = is_ext ? S_E0F0 : S_F0;
        8'h00, 8'hFF: state_next = S_IDLE;
        default: begin
          state_next = S_IDLE;
          ev_entry   = {is_ext, is_brk, in_data};
          if (is_brk) begin
            ev_valid = 1'b1;
            if (same_key) key_down_next = 1'b0;
          end else if (!same_key) begin
            // A make of the already-held key is typematic repeat and is swallowed.
            ev_valid         = 1'b1;
            key_down_next    = 1'b1;
            held_ext_next    = is_ext;
            held_code_next   = in_data;
            press_count_next = press_count_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= S_IDLE;
      key_down_reg    <= 1'b0;
      held_ext_reg    <= 1'b0;
      held_code_reg   <= '0;
      press_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      key_down_reg    <= key_down_next;
      held_ext_reg    <= held_ext_next;
      held_code_reg   <= held_code_next;
      press_count_reg <= press_count_next;
    end
  end

  assign key_down    = key_down_reg;
  assign held_code   = held_code_reg;
  assign press_count = press_count_reg;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          full, pop, push, drop;
  logic [9:0]    head;

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = ev_valid && (!full || pop);
  assign drop      = ev_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= ev_entry;
  end

  // Head is masked while empty so the outputs read zero out of reset.
  assign head = mem[rd_ptr_reg];
  assign {out_ext, out_break, out_code} = out_valid ? head : 10'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: vector table, directed corner sequences and
// randomized bytes checked against a queue-based reference model.
module tb_ps2_key_sequencer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_code;
  logic             out_ext;
  logic             out_break;
  logic             key_down;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] press_count;
  logic             overflow;
  logic             ovf_clr = 1'b0;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ext(out_ext), .out_break(out_break), .key_down(key_down),
    .held_code(held_code), .press_count(press_count), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending-prefix flags, held key and an event queue {ext,brk,code}.
  logic       m_pext, m_pbrk, m_kd, m_hext, m_ovf;
  logic [7:0] m_hcode, m_cnt;
  logic [9:0] mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pext = 0; m_pbrk = 0; m_kd = 0; m_hext = 0; m_ovf = 0;
    m_hcode = 0; m_cnt = 0;
    mq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop, ev;
    logic [9:0] entry;
    pop = (mq.size() != 0) && rdy;
    ev = 0;
    entry = '0;
    if (v) begin
      if (d == 8'hE0) m_pext = 1;
      else if (d == 8'hF0) m_pbrk = 1;
      else if (d == 8'h00 || d == 8'hFF) begin m_pext = 0; m_pbrk = 0; end
      else begin
        entry = {m_pext, m_pbrk, d};
        if (m_pbrk) begin
          ev = 1;
          if (m_kd && m_hext == m_pext && m_hcode == d) m_kd = 0;
        end else if (!(m_kd && m_hext == m_pext && m_hcode == d)) begin
          ev = 1; m_kd = 1; m_hext = m_pext; m_hcode = d; m_cnt = m_cnt + 8'd1;
        end
        m_pext = 0; m_pbrk = 0;
      end
    end
    if (ev && mq.size() == DEPTH && !pop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (ev && (mq.size() < DEPTH)) mq.push_back(entry);
  endtask

  task automatic compare_model();
    logic [9:0] h;
    h = (mq.size() != 0) ? mq[0] : 10'd0;
    check("out_valid", out_valid, (mq.size() != 0));
    check("out_code", out_code, h[7:0]);
    check("out_ext", out_ext, h[9]);
    check("out_break", out_break, h[8]);
    check("key_down", key_down, m_kd);
    check("held_code", held_code, m_hcode);
    check("press_count", press_count, m_cnt);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic apply(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid = v; in_data = d; out_ready = rdy; ovf_clr = clr;
    model_step(v, d, rdy, clr);
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; ovf_clr = 0;
    resetn = 0;
    #2;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_code", {out_ext, out_break, out_code}, 0);
    check("rst.key_down", key_down, 0);
    check("rst.held_code", held_code, 0);
    check("rst.press_count", press_count, 0);
    check("rst.overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    model_reset();
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic rdy;
    logic e_valid; logic [7:0] e_code; logic e_ext; logic e_brk;
    logic e_kd; logic [7:0] e_held; logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic ev, logic [7:0] ec,
                              logic ee, logic eb, logic ek, logic [7:0] eh, logic [7:0] en);
    vec_t t;
    t.v = v; t.d = d; t.rdy = r; t.e_valid = ev; t.e_code = ec; t.e_ext = ee;
    t.e_brk = eb; t.e_kd = ek; t.e_held = eh; t.e_cnt = en;
    return t;
  endfunction

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(1, 8'h1C, 1, 1, 8'h1C, 0, 0, 1, 8'h1C, 1);
    tbl[1]  = mk(1, 8'hF0, 1, 0, 8'h00, 0, 0, 1, 8'h1C, 1);
    tbl[2]  = mk(1, 8'h1C, 1, 1, 8'h1C, 0, 1, 0, 8'h1C, 1);
    tbl[3]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h1C, 1);
    tbl[4]  = mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h1C, 1);
    tbl[5]  = mk(1, 8'h75, 0, 1, 8'h75, 1, 0, 1, 8'h75, 2);
    tbl[6]  = mk(1, 8'hE0, 1, 0, 8'h00, 0, 0, 1, 8'h75, 2);
    tbl[7]  = mk(1, 8'hF0, 1, 0, 8'h00, 0, 0, 1, 8'h75, 2);
    tbl[8]  = mk(1, 8'h75, 1, 1, 8'h75, 1, 1, 0, 8'h75, 2);
    tbl[9]  = mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 8'h75, 3);
    tbl[10] = mk(0, 8'h00, 1, 1, 8'h75, 0, 0, 1, 8'h75, 3);
    tbl[11] = mk(1, 8'h75, 1, 0, 8'h00, 0, 0, 1, 8'h75, 3);
    tbl[12] = mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 1, 8'h75, 3);
    tbl[13] = mk(1, 8'hFF, 0, 0, 8'h00, 0, 0, 1, 8'h75, 3);
    tbl[14] = mk(1, 8'h1C, 0, 1, 8'h1C, 0, 0, 1, 8'h1C, 4);
    tbl[15] = mk(1, 8'h1C, 0, 1, 8'h1C, 0, 0, 1, 8'h1C, 4);
    tbl[16] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 8'h1C, 4);

    model_reset();
    do_reset();

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].rdy, 0);
      check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d.entry", i), {out_ext, out_break, out_code},
            {tbl[i].e_ext, tbl[i].e_brk, tbl[i].e_code});
      check($sformatf("tbl%0d.key_down", i), key_down, tbl[i].e_kd);
      check($sformatf("tbl%0d.held", i), held_code, tbl[i].e_held);
      check($sformatf("tbl%0d.count", i), press_count, tbl[i].e_cnt);
    end

    // Error byte cancels a pending prefix; reset mid-prefix clears everything.
    do_reset();
    apply(1, 8'hE0, 0, 0);
    apply(1, 8'hFF, 0, 0);
    apply(1, 8'h1C, 0, 0);
    check("err.entry", {out_valid, out_ext, out_break, out_code}, {3'b100, 8'h1C});
    apply(1, 8'hF0, 0, 0);
    do_reset();
    apply(1, 8'h32, 0, 0);
    check("postrst.entry", {out_valid, out_ext, out_break, out_code}, {3'b100, 8'h32});
    check("postrst.count", press_count, 1);

    // Overflow: ten distinct makes into a stalled FIFO, then drain in order.
    do_reset();
    for (int k = 0; k < 10; k++) apply(1, 8'h10 + 8'(k), 0, 0);
    check("ovf.overflow", overflow, 1);
    check("ovf.count", press_count, 10);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("drain%0d.code", k), {out_valid, out_code}, {1'b1, 8'h10 + 8'(k)});
      apply(0, 8'h00, 1, 0);
    end
    check("drain.empty", out_valid, 0);
    check("ovf.sticky", overflow, 1);
    apply(0, 8'h00, 0, 1);
    check("ovf.cleared", overflow, 0);

    // Press counter wraps after 256 make/break pairs.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      apply(1, 8'h01 + 8'(i % 8'h50), 1, 0);
      apply(1, 8'hF0, 1, 0);
      apply(1, 8'h01 + 8'(i % 8'h50), 1, 0);
      if (i == 254) check("wrap.count255", press_count, 255);
    end
    check("wrap.count0", press_count, 0);
    check("wrap.key_down", key_down, 0);

    // Randomized bytes against the model, alternating drain-heavy and stall-heavy phases.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic v, rdy, clr;
      logic [7:0] d;
      int pick;
      v = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 11);
      case (pick)
        0, 1:    d = 8'hE0;
        2, 3:    d = 8'hF0;
        4:       d = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        5:       d = 8'h1C;
        6:       d = 8'h75;
        7:       d = 8'h32;
        8:       d = 8'h1D;
        default: d = 8'($urandom_range(1, 8'hDF));
      endcase
      rdy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      apply(v, d, rdy, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
